// File: rtl/ddr_burst_arbiter_pkg.sv
// Shared types and default frame geometry for the DDR burst arbiter and the
// FIFO top-level that wraps it.
package ddr_burst_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_WR   = 2'd2,
        ST_RD   = 2'd3
    } arb_state_e;

    typedef enum logic {
        GRANT_READ  = 1'b0,
        GRANT_WRITE = 1'b1
    } grant_e;

    localparam int          DEF_BURST_LEN   = 128;
    localparam int          DEF_FRAME_WORDS = 192000;
    localparam logic [24:0] DEF_BANK_OFFSET = 25'h0400000;

endpackage

// File: rtl/ddr_frame_addr_gen.sv
// Per-channel frame address generator: bank bit, offset counter with frame
// wrap, pending frame-start handling and current burst length.
module ddr_frame_addr_gen
    import ddr_burst_arbiter_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 25,
    parameter int                    LEN_WIDTH   = 10,
    parameter int                    BURST_LEN   = DEF_BURST_LEN,
    parameter int                    FRAME_WORDS = DEF_FRAME_WORDS,
    parameter logic [ADDR_WIDTH-1:0] BANK_OFFSET = DEF_BANK_OFFSET,
    parameter logic                  BANK_INIT   = 1'b0,
    parameter bit                    TOGGLE      = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic                  apply,
    input  logic                  load_bank,
    input  logic                  advance,
    input  logic [LEN_WIDTH-1:0]  adv_len,
    output logic                  bank_eff_s,
    output logic [LEN_WIDTH-1:0]  cur_len_s,
    output logic [ADDR_WIDTH-1:0] addr_s
);

    localparam int SUM_W = ADDR_WIDTH + 1;

    logic                  bank_r;
    logic                  pending_r;
    logic [ADDR_WIDTH-1:0] offset_r;
    logic [ADDR_WIDTH-1:0] offset_eff_s;
    logic                  start_now_s;
    logic                  new_bank_s;
    logic [SUM_W-1:0]      remain_s;
    logic [SUM_W-1:0]      next_off_s;

    assign start_now_s = apply & pending_r;
    assign new_bank_s  = TOGGLE ? ~bank_r : load_bank;

    // Effective bank/offset with any pending start folded in, plus length and address.
    always_comb begin
        if (start_now_s) begin
            bank_eff_s   = new_bank_s;
            offset_eff_s = {ADDR_WIDTH{1'b0}};
        end else begin
            bank_eff_s   = bank_r;
            offset_eff_s = offset_r;
        end
        remain_s = SUM_W'(FRAME_WORDS) - {1'b0, offset_eff_s};
        if (remain_s < SUM_W'(BURST_LEN)) begin
            cur_len_s = remain_s[LEN_WIDTH-1:0];
        end else begin
            cur_len_s = LEN_WIDTH'(BURST_LEN);
        end
        next_off_s = {1'b0, offset_r} + SUM_W'(adv_len);
        addr_s     = (bank_eff_s ? BANK_OFFSET : {ADDR_WIDTH{1'b0}}) + offset_eff_s;
    end

    // Bank, offset and pending-start registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_r    <= BANK_INIT;
            offset_r  <= {ADDR_WIDTH{1'b0}};
            pending_r <= 1'b0;
        end else begin
            // A start landing in the applying cycle stays pending for the next pass.
            pending_r <= frame_start | (pending_r & ~apply);
            if (start_now_s) begin
                bank_r   <= new_bank_s;
                offset_r <= {ADDR_WIDTH{1'b0}};
            end else if (advance) begin
                if (next_off_s >= SUM_W'(FRAME_WORDS)) begin
                    offset_r <= {ADDR_WIDTH{1'b0}};
                end else begin
                    offset_r <= next_off_s[ADDR_WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/ddr_burst_arbiter.sv
// Round-robin initiator of DDR write/read bursts over a ping-pong frame
// buffer; flags beat-count mismatches as a sticky error.
module ddr_burst_arbiter
    import ddr_burst_arbiter_pkg::*;
#(
    parameter int                    ADDR_WIDTH    = 25,
    parameter int                    LEN_WIDTH     = 10,
    parameter int                    USEDW_WIDTH   = 11,
    parameter int                    BURST_LEN     = DEF_BURST_LEN,
    parameter int                    FRAME_WORDS   = DEF_FRAME_WORDS,
    parameter logic [ADDR_WIDTH-1:0] BANK_OFFSET   = DEF_BANK_OFFSET,
    parameter int                    RD_FIFO_DEPTH = 1024
) (
    input  logic                   mem_clk,
    input  logic                   rst_n,
    input  logic                   local_init_done,
    input  logic                   wr_frame_start,
    input  logic                   rd_frame_start,
    input  logic [USEDW_WIDTH-1:0] wr_fifo_usedw,
    input  logic [USEDW_WIDTH-1:0] rd_fifo_usedw,
    output logic                   wr_burst_req,
    output logic [LEN_WIDTH-1:0]   wr_burst_len,
    output logic [ADDR_WIDTH-1:0]  wr_burst_addr,
    input  logic                   wr_burst_data_req,
    input  logic                   wr_burst_finish,
    output logic                   rd_burst_req,
    output logic [LEN_WIDTH-1:0]   rd_burst_len,
    output logic [ADDR_WIDTH-1:0]  rd_burst_addr,
    input  logic                   rd_burst_data_valid,
    input  logic                   rd_burst_finish,
    output logic                   burst_err
);

    localparam int CMP_W = ((USEDW_WIDTH > LEN_WIDTH) ? USEDW_WIDTH : LEN_WIDTH) + 2;
    localparam int CNT_W = LEN_WIDTH + 1;

    arb_state_e            state_r;
    arb_state_e            state_nxt_s;
    grant_e                last_grant_r;
    logic                  arb_s;
    logic                  wr_bank_eff_s;
    logic                  rd_bank_eff_s;
    logic [LEN_WIDTH-1:0]  wr_cur_len_s;
    logic [LEN_WIDTH-1:0]  rd_cur_len_s;
    logic [ADDR_WIDTH-1:0] wr_addr_s;
    logic [ADDR_WIDTH-1:0] rd_addr_s;
    logic                  wr_elig_s;
    logic                  rd_elig_s;
    logic                  pick_wr_s;
    logic                  pick_rd_s;
    logic                  beat_inc_s;
    logic [CNT_W-1:0]      beat_cnt_r;
    logic [CNT_W-1:0]      beat_total_s;

    assign arb_s = (state_r == ST_ARB);

    ddr_frame_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH), .BURST_LEN(BURST_LEN),
        .FRAME_WORDS(FRAME_WORDS), .BANK_OFFSET(BANK_OFFSET),
        .BANK_INIT(1'b0), .TOGGLE(1'b1)
    ) u_wr_gen (
        .clk(mem_clk), .rst_n(rst_n), .frame_start(wr_frame_start), .apply(arb_s),
        .load_bank(1'b0), .advance((state_r == ST_WR) & wr_burst_finish),
        .adv_len(wr_burst_len), .bank_eff_s(wr_bank_eff_s),
        .cur_len_s(wr_cur_len_s), .addr_s(wr_addr_s)
    );

    // The reader follows the bank the writer has just left, after this cycle's update.
    ddr_frame_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH), .BURST_LEN(BURST_LEN),
        .FRAME_WORDS(FRAME_WORDS), .BANK_OFFSET(BANK_OFFSET),
        .BANK_INIT(1'b1), .TOGGLE(1'b0)
    ) u_rd_gen (
        .clk(mem_clk), .rst_n(rst_n), .frame_start(rd_frame_start), .apply(arb_s),
        .load_bank(~wr_bank_eff_s), .advance((state_r == ST_RD) & rd_burst_finish),
        .adv_len(rd_burst_len), .bank_eff_s(rd_bank_eff_s),
        .cur_len_s(rd_cur_len_s), .addr_s(rd_addr_s)
    );

    // Eligibility, round-robin pick, beat accounting and next state.
    always_comb begin
        wr_elig_s = CMP_W'(wr_fifo_usedw) >= CMP_W'(wr_cur_len_s);
        rd_elig_s = (CMP_W'(rd_fifo_usedw) + CMP_W'(rd_cur_len_s)) <= CMP_W'(RD_FIFO_DEPTH);
        pick_wr_s = wr_elig_s & (~rd_elig_s | (last_grant_r == GRANT_READ));
        pick_rd_s = rd_elig_s & ~pick_wr_s;
        if (state_r == ST_WR) begin
            beat_inc_s = wr_burst_data_req;
        end else if (state_r == ST_RD) begin
            beat_inc_s = rd_burst_data_valid;
        end else begin
            beat_inc_s = 1'b0;
        end
        beat_total_s = beat_cnt_r + CNT_W'(beat_inc_s);
        state_nxt_s  = state_r;
        case (state_r)
            ST_IDLE: begin
                if (local_init_done) state_nxt_s = ST_ARB;
                else                 state_nxt_s = ST_IDLE;
            end
            ST_ARB: begin
                if (!local_init_done) state_nxt_s = ST_IDLE;
                else if (pick_wr_s)   state_nxt_s = ST_WR;
                else if (pick_rd_s)   state_nxt_s = ST_RD;
                else                  state_nxt_s = ST_ARB;
            end
            ST_WR: begin
                if (wr_burst_finish) state_nxt_s = ST_ARB;
                else                 state_nxt_s = ST_WR;
            end
            ST_RD: begin
                if (rd_burst_finish) state_nxt_s = ST_ARB;
                else                 state_nxt_s = ST_RD;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, registered burst requests and the sticky beat-count error.
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            last_grant_r  <= GRANT_READ;
            beat_cnt_r    <= {CNT_W{1'b0}};
            wr_burst_req  <= 1'b0;
            wr_burst_len  <= {LEN_WIDTH{1'b0}};
            wr_burst_addr <= {ADDR_WIDTH{1'b0}};
            rd_burst_req  <= 1'b0;
            rd_burst_len  <= {LEN_WIDTH{1'b0}};
            rd_burst_addr <= {ADDR_WIDTH{1'b0}};
            burst_err     <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                ST_ARB: begin
                    beat_cnt_r <= {CNT_W{1'b0}};
                    if (state_nxt_s == ST_WR) begin
                        wr_burst_req  <= 1'b1;
                        wr_burst_len  <= wr_cur_len_s;
                        wr_burst_addr <= wr_addr_s;
                    end else if (state_nxt_s == ST_RD) begin
                        rd_burst_req  <= 1'b1;
                        rd_burst_len  <= rd_cur_len_s;
                        rd_burst_addr <= rd_addr_s;
                    end
                end
                ST_WR: begin
                    beat_cnt_r <= beat_total_s;
                    if (wr_burst_finish) begin
                        wr_burst_req <= 1'b0;
                        last_grant_r <= GRANT_WRITE;
                        if (beat_total_s != {1'b0, wr_burst_len}) burst_err <= 1'b1;
                    end
                end
                ST_RD: begin
                    beat_cnt_r <= beat_total_s;
                    if (rd_burst_finish) begin
                        rd_burst_req <= 1'b0;
                        last_grant_r <= GRANT_READ;
                        if (beat_total_s != {1'b0, rd_burst_len}) burst_err <= 1'b1;
                    end
                end
                default: beat_cnt_r <= {CNT_W{1'b0}};
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Self-checking bench for ddr_burst_arbiter: acts as the DDR controller and
// compares every request against a frame-level model of the two channels.
module tb_ddr_burst_arbiter;

    localparam int FW    = 1000;
    localparam int BL    = 128;
    localparam int DEPTH = 1024;
    localparam int BANK  = 32'h0400000;

    logic        mem_clk, rst_n, local_init_done, wr_frame_start, rd_frame_start;
    logic [10:0] wr_fifo_usedw, rd_fifo_usedw;
    logic        wr_burst_req, rd_burst_req, burst_err;
    logic [9:0]  wr_burst_len, rd_burst_len;
    logic [24:0] wr_burst_addr, rd_burst_addr;
    logic        wr_burst_data_req, wr_burst_finish, rd_burst_data_valid, rd_burst_finish;

    ddr_burst_arbiter #(.FRAME_WORDS(FW)) dut (
        .mem_clk(mem_clk), .rst_n(rst_n), .local_init_done(local_init_done),
        .wr_frame_start(wr_frame_start), .rd_frame_start(rd_frame_start),
        .wr_fifo_usedw(wr_fifo_usedw), .rd_fifo_usedw(rd_fifo_usedw),
        .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len),
        .wr_burst_addr(wr_burst_addr), .wr_burst_data_req(wr_burst_data_req),
        .wr_burst_finish(wr_burst_finish), .rd_burst_req(rd_burst_req),
        .rd_burst_len(rd_burst_len), .rd_burst_addr(rd_burst_addr),
        .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_finish(rd_burst_finish),
        .burst_err(burst_err)
    );

    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Frame-level model of both channels.
    int m_wr_bank, m_rd_bank, m_wr_off, m_rd_off, m_last;
    bit m_wr_pend, m_rd_pend, m_err;

    typedef struct { int wu; int ru; int ch; int addr; } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: no request within bound", name);
    endtask

    task automatic m_reset();
        m_wr_bank = 0; m_rd_bank = 1; m_wr_off = 0; m_rd_off = 0; m_last = 2;
        m_wr_pend = 0; m_rd_pend = 0; m_err = 0;
    endtask

    function automatic int m_len(input int off);
        return (FW - off < BL) ? FW - off : BL;
    endfunction

    task automatic m_start();
        if (m_wr_pend) begin m_wr_bank = 1 - m_wr_bank; m_wr_off = 0; m_wr_pend = 0; end
        if (m_rd_pend) begin m_rd_bank = 1 - m_wr_bank; m_rd_off = 0; m_rd_pend = 0; end
    endtask

    // Channel the model expects next: 0 none, 1 write, 2 read.
    task automatic m_pick(input int wu, input int ru, output int ch);
        bit we, re;
        m_start();
        we = wu >= m_len(m_wr_off);
        re = ru <= DEPTH - m_len(m_rd_off);
        if (we && re) ch = (m_last == 1) ? 2 : 1;
        else if (we)  ch = 1;
        else if (re)  ch = 2;
        else          ch = 0;
    endtask

    task automatic set_lv(input int wu, input int ru);
        wr_fifo_usedw = 11'(wu);
        rd_fifo_usedw = 11'(ru);
    endtask

    task automatic expect_none(input int cycles);
        bit any = 0;
        repeat (cycles) begin
            @(negedge mem_clk);
            if (wr_burst_req || rd_burst_req) any = 1;
        end
        chk("no_req", 32'(any), 32'd0);
    endtask

    // Serve one burst as the controller. nbeats<0 means exact length.
    // side: 1 wr start mid-burst, 2 rd start mid-burst, 3 wr start with finish, 4 drop init.
    task automatic svc(input int exp_ch, input int nbeats, input bit hold, input bit gap_chk,
                       input int side, output int got_addr);
        int waited = 0, ch, exp_len, exp_addr, nb, b = 0;
        bit seen = 0, side_done = 0, s;
        logic [9:0]  len0;
        logic [24:0] addr0;
        got_addr = -1;
        while (!seen && waited < 64) begin
            @(negedge mem_clk);
            waited++;
            if (wr_burst_req || rd_burst_req) seen = 1;
        end
        if (!seen) begin note_fail("req_timeout"); return; end
        if (gap_chk) chk("arb_gap", 32'(waited), 32'd1);
        chk("one_req", 32'(wr_burst_req & rd_burst_req), 32'd0);
        ch = wr_burst_req ? 1 : 2;
        chk("grant_ch", 32'(ch), 32'(exp_ch));
        m_start();
        if (ch == 1) begin
            exp_len = m_len(m_wr_off); exp_addr = m_wr_bank * BANK + m_wr_off;
            len0 = wr_burst_len; addr0 = wr_burst_addr;
        end else begin
            exp_len = m_len(m_rd_off); exp_addr = m_rd_bank * BANK + m_rd_off;
            len0 = rd_burst_len; addr0 = rd_burst_addr;
        end
        chk("burst_len", 32'(len0), 32'(exp_len));
        chk("burst_addr", 32'(addr0), 32'(exp_addr));
        got_addr = int'(addr0);
        nb = (nbeats < 0) ? exp_len : nbeats;
        while (b < nb) begin
            @(negedge mem_clk);
            wr_frame_start = 1'b0; rd_frame_start = 1'b0;
            if (!side_done && b >= nb / 2) begin
                side_done = 1;
                case (side)
                    1: begin wr_frame_start = 1'b1; m_wr_pend = 1; end
                    2: begin rd_frame_start = 1'b1; m_rd_pend = 1; end
                    4: local_init_done = 1'b0;
                    default: ;
                endcase
            end
            s = ($urandom_range(0, 3) != 0);
            if (ch == 1) wr_burst_data_req = s; else rd_burst_data_valid = s;
            if (s) b++;
        end
        @(negedge mem_clk);
        wr_burst_data_req = 1'b0; rd_burst_data_valid = 1'b0;
        wr_frame_start = 1'b0; rd_frame_start = 1'b0;
        if (ch == 1) begin
            chk("hold_req", 32'(wr_burst_req), 32'd1);
            chk("hold_len", 32'(wr_burst_len), 32'(exp_len));
            chk("hold_addr", 32'(wr_burst_addr), 32'(exp_addr));
        end else begin
            chk("hold_req", 32'(rd_burst_req), 32'd1);
            chk("hold_len", 32'(rd_burst_len), 32'(exp_len));
            chk("hold_addr", 32'(rd_burst_addr), 32'(exp_addr));
        end
        if (!hold) set_lv(0, 2047);
        if (ch == 1) wr_burst_finish = 1'b1; else rd_burst_finish = 1'b1;
        if (side == 3) begin wr_frame_start = 1'b1; m_wr_pend = 1; end
        @(negedge mem_clk);
        wr_burst_finish = 1'b0; rd_burst_finish = 1'b0; wr_frame_start = 1'b0;
        chk("req_drop", 32'(wr_burst_req | rd_burst_req), 32'd0);
        if (ch == 1) begin m_wr_off += exp_len; if (m_wr_off >= FW) m_wr_off = 0; end
        else         begin m_rd_off += exp_len; if (m_rd_off >= FW) m_rd_off = 0; end
        m_last = ch;
        if (nb != exp_len) m_err = 1;
        chk("burst_err", 32'(burst_err), 32'(m_err));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; local_init_done = 1'b0;
        wr_frame_start = 1'b0; rd_frame_start = 1'b0;
        wr_burst_data_req = 1'b0; wr_burst_finish = 1'b0;
        rd_burst_data_valid = 1'b0; rd_burst_finish = 1'b0;
        set_lv(0, 2047);
        m_reset();
        repeat (3) @(negedge mem_clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, ch, wu, ru, side, k;
        bit seen;
        tbl[0] = '{200, 1000, 1, 0};
        tbl[1] = '{100, 1000, 0, -1};
        tbl[2] = '{127,  896, 2, 32'h0400000};
        tbl[3] = '{128,  897, 1, 128};
        tbl[4] = '{300,    0, 2, 32'h0400080};
        tbl[5] = '{300,    0, 1, 256};
        tbl[6] = '{300,    0, 2, 32'h0400100};
        tbl[7] = '{0,   2047, 0, -1};

        do_reset();
        set_lv(300, 0);
        chk("rst_wr_req", 32'(wr_burst_req), 32'd0);
        chk("rst_wr_len", 32'(wr_burst_len), 32'd0);
        chk("rst_wr_addr", 32'(wr_burst_addr), 32'd0);
        chk("rst_rd_req", 32'(rd_burst_req), 32'd0);
        chk("rst_rd_len", 32'(rd_burst_len), 32'd0);
        chk("rst_rd_addr", 32'(rd_burst_addr), 32'd0);
        chk("rst_err", 32'(burst_err), 32'd0);
        rst_n = 1'b1;
        expect_none(10);
        local_init_done = 1'b1;

        for (int i = 0; i < 8; i++) begin
            set_lv(tbl[i].wu, tbl[i].ru);
            if (tbl[i].ch == 0) begin
                expect_none(12);
            end else begin
                svc(tbl[i].ch, -1, 1'b0, 1'b0, 0, a);
                chk("tbl_addr", 32'(a), 32'(tbl[i].addr));
            end
        end

        // Back-to-back writes through the short last burst and the frame wrap.
        set_lv(300, 2047);
        for (k = 0; k < 6; k++) begin
            svc(1, -1, k < 5, k > 0, 0, a);
            if (k == 4) chk("short_burst_addr", 32'(a), 32'd896);
            if (k == 5) chk("wrap_addr", 32'(a), 32'd0);
        end

        // Frame starts during bursts and on the finish cycle.
        set_lv(300, 2047); svc(1, -1, 1'b0, 1'b0, 1, a);
        set_lv(300, 2047); svc(1, -1, 1'b0, 1'b0, 0, a);
        chk("fs_wr_addr", 32'(a), 32'h0400000);
        set_lv(0, 0); svc(2, -1, 1'b0, 1'b0, 2, a);
        set_lv(0, 0); svc(2, -1, 1'b0, 1'b0, 0, a);
        chk("fs_rd_addr", 32'(a), 32'd0);
        set_lv(300, 2047); svc(1, -1, 1'b0, 1'b0, 3, a);
        set_lv(300, 2047); svc(1, -1, 1'b0, 1'b0, 0, a);
        chk("fs_fin_addr", 32'(a), 32'd0);

        // Strobes while arbitrating must not count as beats.
        repeat (5) begin
            @(negedge mem_clk);
            wr_burst_data_req = 1'b1; rd_burst_data_valid = 1'b1;
        end
        @(negedge mem_clk);
        wr_burst_data_req = 1'b0; rd_burst_data_valid = 1'b0;
        set_lv(300, 2047); svc(1, -1, 1'b0, 1'b0, 0, a);

        // Randomised fill levels and frame starts against the model.
        for (int it = 0; it < 40; it++) begin
            wu = $urandom_range(0, 300);
            ru = $urandom_range(700, 1100);
            side = $urandom_range(0, 6);
            if (side > 3) side = 0;
            set_lv(wu, ru);
            m_pick(wu, ru, ch);
            if (ch == 0) begin
                expect_none(8);
            end else begin
                svc(ch, -1, 1'b0, 1'b0, side, a);
            end
        end

        // Short burst sets the sticky error; a correct burst does not clear it.
        set_lv(300, 2047); svc(1, 127, 1'b0, 1'b0, 0, a);
        chk("err_set", 32'(burst_err), 32'd1);
        set_lv(300, 2047); svc(1, -1, 1'b0, 1'b0, 0, a);
        chk("err_sticky", 32'(burst_err), 32'd1);

        // Asynchronous reset in the middle of a burst.
        set_lv(300, 2047);
        seen = 0;
        for (int w = 0; w < 64 && !seen; w++) begin
            @(negedge mem_clk);
            if (wr_burst_req) seen = 1;
        end
        if (!seen) note_fail("rst_mid_req");
        rst_n = 1'b0;
        #1;
        chk("rst_mid_wr_req", 32'(wr_burst_req), 32'd0);
        chk("rst_mid_rd_req", 32'(rd_burst_req), 32'd0);
        chk("rst_mid_err", 32'(burst_err), 32'd0);
        do_reset();
        rst_n = 1'b1;

        // init_done falls during a read: burst completes, then no more requests.
        local_init_done = 1'b1;
        set_lv(0, 0);
        svc(2, -1, 1'b0, 1'b0, 4, a);
        chk("init_rd_addr", 32'(a), 32'h0400000);
        set_lv(300, 0);
        expect_none(30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr_burst_arbiter.md
Name: ddr_burst_arbiter

Overview:
- Initiator for the DDR burst user interface: decides when to issue write bursts (camera-side FIFO to DDR) and read bursts (DDR to LCD-side FIFO), and generates burst length and address.
- Keeps per-channel frame address counters over a two-bank ping-pong frame buffer so the reader never scans the bank the writer is filling.
- Sits between the video FIFOs and the DDR controller; runs in the controller's phy clock domain.

Parameters:
- ADDR_WIDTH, 25, burst address width in words.
- LEN_WIDTH, 10, burst length width.
- USEDW_WIDTH, 11, FIFO fill-level width.
- BURST_LEN, 128, nominal burst length in words (1..1023).
- FRAME_WORDS, 192000, words per frame (800x480 at 16 bpp, 32-bit words).
- BANK_OFFSET, 25'h0400000, word offset between bank 0 and bank 1.
- RD_FIFO_DEPTH, 1024, read FIFO capacity in words.

Ports:
- mem_clk  in  1  phy clock from DDR controller
- rst_n  in  1  asynchronous active-low reset
- local_init_done  in  1  DDR calibration done
- wr_frame_start  in  1  one-cycle pulse, camera frame begins (synchronised upstream)
- rd_frame_start  in  1  one-cycle pulse, LCD frame begins
- wr_fifo_usedw  in  USEDW_WIDTH  words waiting in write FIFO
- rd_fifo_usedw  in  USEDW_WIDTH  words held in read FIFO
- wr_burst_req  out  1  write burst request
- wr_burst_len  out  LEN_WIDTH  write burst length
- wr_burst_addr  out  ADDR_WIDTH  write burst start address
- wr_burst_data_req  in  1  controller beat strobe for write data
- wr_burst_finish  in  1  write burst complete pulse
- rd_burst_req  out  1  read burst request
- rd_burst_len  out  LEN_WIDTH  read burst length
- rd_burst_addr  out  ADDR_WIDTH  read burst start address
- rd_burst_data_valid  in  1  controller read beat strobe
- rd_burst_finish  in  1  read burst complete pulse
- burst_err  out  1  sticky: beat count at finish differed from length

Behaviour:
- Reset: all outputs 0; state IDLE; wr_bank=0; rd_bank=1; offsets 0; pending flags 0; last_grant=READ.
- States: IDLE, ARB, WR, RD.
- IDLE -> ARB when local_init_done=1. Bursts are never issued before then.
- ARB:
  - Apply any pending frame start first.
    - Pending write start: wr_bank toggles, wr_offset=0.
    - Pending read start: rd_bank takes the value !wr_bank, meaning the last bank the writer completed; rd_offset=0.
  - Eligibility, evaluated the same cycle on the updated counters:
    - Write eligible when wr_fifo_usedw >= cur_wr_len.
    - Read eligible when rd_fifo_usedw <= RD_FIFO_DEPTH - cur_rd_len.
  - Both eligible: grant the channel opposite to last_grant (round-robin).
  - Grant -> WR or RD on the next edge. No grant -> stay in ARB.
- cur_len = min(BURST_LEN, FRAME_WORDS - offset), computed with an (ADDR_WIDTH+1)-bit subtract. This gives a short last burst of FRAME_WORDS mod BURST_LEN words when that is nonzero.
- WR:
  - wr_burst_req=1, with len and addr = bank*BANK_OFFSET + wr_offset, all registered on entry.
  - req, len and addr are held stable until wr_burst_finish is sampled.
  - On that cycle: req drops, wr_offset += len (wraps to 0 when it reaches FRAME_WORDS), last_grant=WRITE, -> ARB.
  - RD is symmetric.
- Request-to-request spacing: minimum one ARB cycle between bursts.
- Beat counter: cleared on entering WR/RD; counts wr_burst_data_req (WR) or rd_burst_data_valid (RD). If count != len at finish, burst_err=1 until reset.
- Frame start handling:
  - A frame_start arriving in any state sets its pending flag, which is cleared when applied in ARB.
  - A burst in flight is never aborted or modified.
  - Frame start in the same cycle as finish: the offset advances first, then the pending flag zeroes it in the next ARB.
- local_init_done falling: the current burst completes normally, then ARB -> IDLE.
- Asynchronous reset mid-burst: requests drop immediately. The controller's own reset recovery is the controller's responsibility.
- Strobes arriving outside WR/RD are ignored (they do not count beats).

Decomposition:
- Shared package holds:
  - State encoding (IDLE/ARB/WR/RD, 2 bits).
  - Grant encoding.
  - Default BURST_LEN, FRAME_WORDS and BANK_OFFSET constants, also used by the FIFO top-level.
- One natural sub-module: ddr_frame_addr_gen, instantiated once per channel. It holds the bank bit, offset counter, cur_len computation, wrap and pending-start handling.

Test Plan:
- Reset, then local_init_done=1 with wr_fifo_usedw=200 and rd_fifo_usedw=1000 -> wr_burst_req, len=128, addr=0x400000 (bank 1 after reset toggle only if wr_frame_start was given; otherwise addr=0). Finish after 128 beats -> next write addr=+128, burst_err=0.
- Hold write eligible (usedw=300) and read eligible (usedw=0) -> grants alternate W,R,W,R. Each request is preceded by one ARB cycle.
- FRAME_WORDS=192000, BURST_LEN=128 (1500 bursts exactly); then FRAME_WORDS=1000 -> 8th burst len=104 at offset 896, and the next burst wraps to offset 0.
- Pulse wr_frame_start mid-WR -> current burst keeps addr/len. Next write starts at offset 0 of the toggled bank; a following rd_frame_start selects the other bank.
- Assert wr_burst_finish after only 127 wr_burst_data_req beats -> burst_err=1 and stays 1. A subsequent correct burst does not clear it; rst_n low clears it.
- Drop local_init_done during RD -> finish accepted, then IDLE, with no further requests while init_done=0.
